alsu_seq: RTL and testbench

Parametrised next-generation arithmetic/logic/shift unit with a valid/ready operand interface. Operand width is configurable and the result register is double-width. Multiply is an iterative one-bit-per-cycle signed unit, and completion is flagged with a one-cycle out_valid pulse. It sits in the same datapath slot as the existing ALSU. Its source must honour the handshake instead of presenting operands every cycle.

---
 rtl/alsu_seq_if.sv | 50 +++++
 rtl/alsu_seq.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alsu_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_seq_if.sv
// alsu_seq_if: operand/result bundle of the alsu_seq unit.
//
// Signals
//   in_valid / in_ready : operand bundle handshake (source -> unit)
//   A, B, cin, opcode   : operands, carry-in and operation select
//   red_op_A/B          : reduction selects
//   bypass_A/B          : operand pass-through selects
//   direction           : shift/rotate direction, 1 = left
//   serial_in           : fill bit for shift
//   out, out_valid, err : result register, completion pulse, error qualifier
//   leds                : error indicator
//   dbg_state           : FSM state of the unit, for observation only
//
// Modports
//   master : operand source (drives the bundle, observes results)
//   slave  : the unit itself
interface alsu_seq_if #(
   parameter int WIDTH = 8,
   parameter int LED_W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 cin;
   logic [2:0]           opcode;
   logic                 red_op_A;
   logic                 red_op_B;
   logic                 bypass_A;
   logic                 bypass_B;
   logic                 direction;
   logic                 serial_in;
   logic [2*WIDTH-1:0]   out;
   logic                 out_valid;
   logic                 err;
   logic [LED_W-1:0]     leds;
   logic [1:0]           dbg_state;

   modport master (
      output in_valid, A, B, cin, opcode, red_op_A, red_op_B,
             bypass_A, bypass_B, direction, serial_in,
      input  in_ready, out, out_valid, err, leds, dbg_state
   );

   modport slave (
      input  in_valid, A, B, cin, opcode, red_op_A, red_op_B,
             bypass_A, bypass_B, direction, serial_in,
      output in_ready, out, out_valid, err, leds, dbg_state
   );
endinterface

// File: rtl/alsu_seq.sv
// alsu_seq: sequential arithmetic/logic/shift unit with a valid/ready
// operand interface and a double-width result register.
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, overrides everything
//   bus  : alsu_seq_if.slave bundle (operands in, result/status out)
//
// Handshake: a bundle transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE; while it is low
// the bundle inputs are ignored and the source must hold its bundle.
// out_valid is a one-cycle pulse on the cycle after out was written; err
// is meaningful only while out_valid is high. in_ready is already high in
// that same cycle, so a new bundle can be accepted back-to-back.
//
// Timing: non-multiply result one edge after accept; a valid multiply
// (opcode 3) takes WIDTH edges, one partial product per edge.
module alsu_seq #(
   parameter int WIDTH          = 8,
   parameter     INPUT_PRIORITY = "A",
   parameter     FULL_ADDER     = "ON",
   parameter int LED_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   alsu_seq_if.slave  bus
);

   localparam int OW      = 2 * WIDTH;
   localparam int CW      = $clog2(WIDTH);
   localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
   localparam bit USE_CIN = (FULL_ADDER == "ON");

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2
   } state_e;

   // A bundle is invalid for opcodes 6/7, or for a reduction request on
   // any opcode other than AND/XOR.
   function automatic logic bundle_invalid(input logic [2:0] op,
                                           input logic       ra,
                                           input logic       rb);
      return (op[2] & op[1]) | ((ra | rb) & (op[2] | op[1]));
   endfunction

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    a_q, a_d;
   logic [WIDTH-1:0]    b_q, b_d;
   logic                cin_q, cin_d;
   logic [2:0]          opcode_q, opcode_d;
   logic                red_a_q, red_a_d;
   logic                red_b_q, red_b_d;
   logic                byp_a_q, byp_a_d;
   logic                byp_b_q, byp_b_d;
   logic                dir_q, dir_d;
   logic                sin_q, sin_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [OW-1:0]       acc_q, acc_d;
   logic [OW-1:0]       out_q, out_d;
   logic                out_valid_q, out_valid_d;
   logic                err_q, err_d;
   logic [LED_W-1:0]    leds_q, leds_d;

   // Datapath intermediates
   logic                accept;
   logic                inv_cap;
   logic [WIDTH-1:0]    mag_a;
   logic [WIDTH-1:0]    mag_b;
   logic                neg_prod;
   logic [OW-1:0]       pp;
   logic [OW-1:0]       mul_sum;
   logic [OW-1:0]       product;
   logic [WIDTH:0]      sum_w;
   logic [WIDTH-1:0]    and_ab;
   logic [WIDTH-1:0]    xor_ab;
   logic [WIDTH-1:0]    red_sel;
   logic [WIDTH-1:0]    byp_sel;
   logic [OW-1:0]       shift_v;
   logic [OW-1:0]       rot_v;
   logic [OW-1:0]       res;

   // ------------------------------------------------------------------
   // Result datapath, evaluated from the captured bundle
   // ------------------------------------------------------------------
   always_comb begin
      inv_cap  = bundle_invalid(opcode_q, red_a_q, red_b_q);

      // Multiply runs on magnitudes; the sign is restored at the last edge.
      // The most negative operand maps to 2^(WIDTH-1), which still fits
      // in WIDTH unsigned bits.
      mag_a    = a_q[WIDTH-1] ? -a_q : a_q;
      mag_b    = b_q[WIDTH-1] ? -b_q : b_q;
      neg_prod = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      pp       = {{WIDTH{1'b0}}, mag_a} << cnt_q;
      if (!mag_b[cnt_q]) begin
         pp = '0;
      end
      mul_sum  = acc_q + pp;
      product  = neg_prod ? -mul_sum : mul_sum;

      // WIDTH+1-bit sum keeps the carry, so no overflow is lost.
      sum_w    = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q}
               + {{WIDTH{1'b0}}, cin_q & USE_CIN};

      and_ab   = a_q & b_q;
      xor_ab   = a_q ^ b_q;

      if (red_a_q && red_b_q) begin
         red_sel = PRIO_A ? a_q : b_q;
      end else if (red_a_q) begin
         red_sel = a_q;
      end else begin
         red_sel = b_q;
      end

      if (byp_a_q && byp_b_q) begin
         byp_sel = PRIO_A ? a_q : b_q;
      end else if (byp_a_q) begin
         byp_sel = a_q;
      end else begin
         byp_sel = b_q;
      end

      // Shift/rotate act on the result register as it stood at accept;
      // out_q does not change while the op is in flight.
      shift_v  = dir_q ? {out_q[OW-2:0], sin_q} : {sin_q, out_q[OW-1:1]};
      rot_v    = dir_q ? {out_q[OW-2:0], out_q[OW-1]}
                       : {out_q[0], out_q[OW-1:1]};

      res = '0;
      if (byp_a_q || byp_b_q) begin
         res = {{WIDTH{byp_sel[WIDTH-1]}}, byp_sel};
      end else begin
         unique case (opcode_q)
            3'd0: begin
               if (red_a_q || red_b_q) begin
                  res = {{(OW-1){1'b0}}, &red_sel};
               end else begin
                  res = {{WIDTH{and_ab[WIDTH-1]}}, and_ab};
               end
            end
            3'd1: begin
               if (red_a_q || red_b_q) begin
                  res = {{(OW-1){1'b0}}, ^red_sel};
               end else begin
                  res = {{WIDTH{xor_ab[WIDTH-1]}}, xor_ab};
               end
            end
            3'd2:    res = {{(WIDTH-1){sum_w[WIDTH]}}, sum_w};
            3'd3:    res = product;
            3'd4:    res = shift_v;
            3'd5:    res = rot_v;
            default: res = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and register updates
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      cin_d       = cin_q;
      opcode_d    = opcode_q;
      red_a_d     = red_a_q;
      red_b_d     = red_b_q;
      byp_a_d     = byp_a_q;
      byp_b_d     = byp_b_q;
      dir_d       = dir_q;
      sin_d       = sin_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      err_d       = err_q;
      leds_d      = leds_q;

      accept = bus.in_valid && (state_q == S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d      = bus.A;
               b_d      = bus.B;
               cin_d    = bus.cin;
               opcode_d = bus.opcode;
               red_a_d  = bus.red_op_A;
               red_b_d  = bus.red_op_B;
               byp_a_d  = bus.bypass_A;
               byp_b_d  = bus.bypass_B;
               dir_d    = bus.direction;
               sin_d    = bus.serial_in;
               cnt_d    = '0;
               acc_d    = '0;
               if (bus.opcode == 3'd3 &&
                   !bundle_invalid(bus.opcode, bus.red_op_A, bus.red_op_B)) begin
                  state_d = S_MUL;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
         end
         S_MUL: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               acc_d   = '0;
            end else begin
               acc_d = mul_sum;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Completion: EXEC always finishes on its single edge; MUL on its
      // last partial product.
      if ((state_q == S_EXEC) ||
          (state_q == S_MUL && cnt_q == CW'(WIDTH - 1))) begin
         out_valid_d = 1'b1;
         if (inv_cap) begin
            out_d  = '0;
            err_d  = 1'b1;
            leds_d = ~leds_q;
         end else begin
            out_d  = res;
            err_d  = 1'b0;
            leds_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         opcode_q    <= '0;
         red_a_q     <= 1'b0;
         red_b_q     <= 1'b0;
         byp_a_q     <= 1'b0;
         byp_b_q     <= 1'b0;
         dir_q       <= 1'b0;
         sin_q       <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         leds_q      <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cin_q       <= cin_d;
         opcode_q    <= opcode_d;
         red_a_q     <= red_a_d;
         red_b_q     <= red_b_d;
         byp_a_q     <= byp_a_d;
         byp_b_q     <= byp_b_d;
         dir_q       <= dir_d;
         sin_q       <= sin_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         leds_q      <= leds_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.err       = err_q;
   assign bus.leds      = leds_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alsu_seq.sv
// tb_alsu_seq: scoreboard bench for alsu_seq (WIDTH=8, priority A,
// full adder on). A driver issues bundles through the handshake and pushes
// the expected {out, err, leds} and completion edge into queues; a monitor
// pops and compares whenever out_valid is seen.
module tb_alsu_seq;

   localparam int W     = 8;
   localparam int OW    = 16;
   localparam int LW    = 16;
   localparam bit PRIO_A = 1'b1;
   localparam bit FA_ON  = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alsu_seq_if #(.WIDTH(W), .LED_W(LW)) bus ();

   alsu_seq #(
      .WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [OW+LW:0] exp_q[$];
   int             exp_cyc_q[$];
   logic [OW-1:0]  m_out  = '0;
   logic [LW-1:0]  m_leds = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation rules.
   task automatic predict(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [2:0] op, input logic ra, input logic rb,
                          input logic ba, input logic bb, input logic dr, input logic si,
                          output logic [OW+LW:0] e, output int lat);
      int sa, sb;
      logic [W-1:0] v;
      logic [OW-1:0] r;
      bit bad;
      sa  = $signed(a);
      sb  = $signed(b);
      bad = (op >= 3'd6) || ((ra || rb) && op > 3'd1);
      r   = '0;
      if (ra && rb) v = PRIO_A ? a : b;
      else          v = ra ? a : b;
      if (bad) begin
         m_leds = ~m_leds;
      end else begin
         m_leds = '0;
         if (ba && bb)  r = PRIO_A ? 16'(sa) : 16'(sb);
         else if (ba)   r = 16'(sa);
         else if (bb)   r = 16'(sb);
         else begin
            case (op)
               3'd0: r = (ra || rb) ? ((v == 8'hFF) ? 16'd1 : 16'd0)
                                    : 16'(int'($signed(a & b)));
               3'd1: r = (ra || rb) ? 16'($countones(v) % 2)
                                    : 16'(int'($signed(a ^ b)));
               3'd2: r = 16'(sa + sb + (FA_ON ? int'(ci) : 0));
               3'd3: r = 16'(sa * sb);
               3'd4: r = dr ? ((m_out << 1) | 16'(si)) : ((m_out >> 1) | (16'(si) << 15));
               3'd5: r = dr ? ((m_out << 1) | (m_out >> 15)) : ((m_out >> 1) | (m_out << 15));
               default: r = '0;
            endcase
         end
      end
      m_out = r;
      e     = {r, bad, m_leds};
      lat   = (op == 3'd3 && !bad) ? W : 1;
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [2:0] op, input logic ra, input logic rb,
                       input logic ba, input logic bb, input logic dr, input logic si);
      int t;
      logic [OW+LW:0] e;
      int lat;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
         return;
      end
      bus.A = a; bus.B = b; bus.cin = ci; bus.opcode = op;
      bus.red_op_A = ra; bus.red_op_B = rb; bus.bypass_A = ba; bus.bypass_B = bb;
      bus.direction = dr; bus.serial_in = si;
      bus.in_valid = 1'b1;
      predict(a, b, ci, op, ra, rb, ba, bb, dr, si, e, lat);
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 1 + lat);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      // Scramble the bundle while the unit is busy; it must not be sampled.
      bus.A = W'($urandom); bus.B = W'($urandom); bus.opcode = 3'($urandom);
      bus.cin = 1'($urandom); bus.direction = 1'($urandom); bus.serial_in = 1'($urandom);
   endtask

   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [2:0] op);
      send(a, b, ci, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   logic [OW+LW:0] mon_e;
   int             mon_c;
   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out=%0h expected no pulse (t=%0t)", bus.out, $time);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            chk("out",     64'(bus.out),  64'(mon_e[OW+LW:LW+1]));
            chk("err",     64'(bus.err),  64'(mon_e[LW]));
            chk("leds",    64'(bus.leds), 64'(mon_e[LW-1:0]));
            chk("latency", 64'(cyc),      64'(mon_c));
            chk("in_ready_at_done", 64'(bus.in_ready), 64'd1);
         end
      end
   end

   // ---------------- stimulus ----------------
   int pulses;
   int t_drain;
   initial begin
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.opcode = '0;
      bus.red_op_A = 1'b0; bus.red_op_B = 1'b0; bus.bypass_A = 1'b0; bus.bypass_B = 1'b0;
      bus.direction = 1'b0; bus.serial_in = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_out",       64'(bus.out),       64'd0);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_err",       64'(bus.err),       64'd0);
      chk("reset_leds",      64'(bus.leds),      64'd0);
      chk("reset_in_ready",  64'(bus.in_ready),  64'd1);

      // Add with carry, signed multiplies (incl. most-negative squared)
      send_op(8'd100, 8'd50, 1'b1, 3'd2);
      send_op(8'hFD, 8'h07, 1'b0, 3'd3);
      send_op(8'h80, 8'h80, 1'b0, 3'd3);
      send_op(8'h00, 8'h5A, 1'b0, 3'd3);
      send_op(8'h7F, 8'h80, 1'b1, 3'd2);

      // Invalid bundles toggle leds; a valid op clears them
      send_op(8'h12, 8'h34, 1'b0, 3'd6);
      send_op(8'h12, 8'h34, 1'b0, 3'd7);
      send(8'h01, 8'h02, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h01, 8'h02, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_op(8'hF0, 8'h3C, 1'b0, 3'd0);

      // Shift/rotate chain from out = 3 -> 8001 -> 0002 -> 0001 -> 8000
      send_op(8'd1, 8'd1, 1'b1, 3'd2);
      send(8'h00, 8'h00, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h00, 8'h00, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h00, 8'h00, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h00, 8'h00, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h00, 8'h00, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Bypass and reduction priority
      send(8'h80, 8'h01, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'hFF, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h07, 8'hFF, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h05, 8'h9C, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
              1'($urandom), 1'($urandom));
      end

      // Reset during a multiply: leave leds set first so the clear is visible
      send_op(8'h00, 8'h00, 1'b0, 3'd7);
      send_op(8'h13, 8'hEE, 1'b0, 3'd3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      exp_cyc_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_out  = '0;
      m_leds = '0;
      chk("abort_out",       64'(bus.out),       64'd0);
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
      chk("abort_leds",      64'(bus.leds),      64'd0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      chk("abort_no_pulse", 64'(pulses), 64'd0);

      // One op after the abort to confirm the unit restarted cleanly
      send_op(8'hFE, 8'hFE, 1'b0, 3'd3);

      // Drain
      t_drain = 0;
      while (exp_q.size() != 0 && t_drain < 200) begin
         @(negedge clk);
         t_drain++;
      end
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
